fpu_rr_scheduler: RTL

- Shares one combinational FPU (add/sub/mul/div, IEEE-754 double, op encoding 00 add, 01 sub, 10 mul, 11 div) between NUM_REQ requesters.
- Arbitrates round-robin and registers the winning operands into an issue stage.
- Captures the FPU output into a result stage and returns it with the requester ID over a valid/ready response channel.
- Sits between requester pipelines and the FPU instance, which it instantiates internally.

---
 rtl/fpu_rr_scheduler.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/fpu_rr_scheduler.sv
// fpu_rr_scheduler: round-robin sharing of one combinational IEEE-754 double FPU between NUM_REQ requesters
//   clk, rst_n (sync, active-low)
//   req_valid/req_ready/req_a/req_b/req_op : packed per-requester request channel, one grant at a time
//   rsp_valid/rsp_ready/rsp_id/rsp_result  : registered response channel, accept order
//   busy                                   : issue or result stage occupied
module fpu_core (
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic [1:0]  op,
    output logic [63:0] y
);
    localparam logic [63:0] QNAN = 64'h7FF8_0000_0000_0000;

    function automatic logic [7:0] lzc(input logic [127:0] x);
        lzc = 8'd128;
        for (int i = 0; i < 128; i++)
            if (x[i]) lzc = 8'(127 - i);
    endfunction

    logic         sa, sb, sx, sr, spec, st, rnd, swap;
    logic         nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
    logic [10:0]  xa, xb;
    logic [52:0]  ma, mb, na, nb;
    logic [7:0]   la, lb, lz;
    logic [13:0]  ea, eb, e, d, ef;
    logic [127:0] m, big, sml, sh;
    logic [105:0] prod;
    logic [55:0]  q;
    logic [54:0]  rem;
    logic [53:0]  sum;
    logic [63:0]  y_spec;

    // m is an unsigned magnitude whose bit 127 weighs 2^(e-1023); all ops meet in one normalise/round path
    always_comb begin
        sa = a[63];
        sb = b[63] ^ (op == 2'b01);
        sx = a[63] ^ b[63];
        xa = a[62:52];
        xb = b[62:52];
        ma = {|xa, a[51:0]};
        mb = {|xb, b[51:0]};
        ea = {3'b0, (|xa) ? xa : 11'd1};
        eb = {3'b0, (|xb) ? xb : 11'd1};
        nan_a = (&xa) & (|a[51:0]);
        nan_b = (&xb) & (|b[51:0]);
        inf_a = (&xa) & ~(|a[51:0]);
        inf_b = (&xb) & ~(|b[51:0]);
        zero_a = ~(|a[62:0]);
        zero_b = ~(|b[62:0]);
        la = lzc({ma, 75'b0});
        lb = lzc({mb, 75'b0});
        na = ma << la;
        nb = mb << lb;
        swap = {ea, ma} < {eb, mb};
        spec = 1'b1;
        y_spec = QNAN;
        sr = sx;
        e = '0;
        m = '0;
        big = '0;
        sml = '0;
        sh = '0;
        d = '0;
        prod = '0;
        q = '0;
        rem = '0;
        if (!op[1]) begin
            if (nan_a | nan_b | (inf_a & inf_b & (sa != sb))) y_spec = QNAN;
            else if (inf_a | inf_b) y_spec = {inf_a ? sa : sb, 11'h7FF, 52'b0};
            else begin
                spec = 1'b0;
                big = {1'b0, swap ? mb : ma, 74'b0};
                sml = {1'b0, swap ? ma : mb, 74'b0};
                d = swap ? eb - ea : ea - eb;
                sh = sml >> d;
                sh[0] = sh[0] | ((sh << d) != sml);
                m = (sa == sb) ? big + sh : big - sh;
                e = (swap ? eb : ea) + 14'd1;
                sr = (m == '0) ? (sa & sb) : (swap ? sb : sa);
            end
        end else if (!op[0]) begin
            if (nan_a | nan_b | (inf_a & zero_b) | (inf_b & zero_a)) y_spec = QNAN;
            else if (inf_a | inf_b) y_spec = {sx, 11'h7FF, 52'b0};
            else if (zero_a | zero_b) y_spec = {sx, 63'b0};
            else begin
                spec = 1'b0;
                prod = na * nb;
                m = {prod, 22'b0};
                e = ea - {6'b0, la} + eb - {6'b0, lb} - 14'd1022;
            end
        end else begin
            if (nan_a | nan_b | (inf_a & inf_b) | (zero_a & zero_b)) y_spec = QNAN;
            else if (inf_a | zero_b) y_spec = {sx, 11'h7FF, 52'b0};
            else if (zero_a | inf_b) y_spec = {sx, 63'b0};
            else begin
                spec = 1'b0;
                rem = {2'b0, na};
                for (int i = 55; i >= 0; i--) begin
                    q[i] = rem >= {2'b0, nb};
                    if (q[i]) rem = rem - {2'b0, nb};
                    rem = rem << 1;
                end
                m = {q, 72'b0} | {127'b0, |rem};
                e = ea - {6'b0, la} - eb + {6'b0, lb} + 14'd1023;
            end
        end
        lz = lzc(m);
        m = m << lz;
        e = e - {6'b0, lz};
        // below the normal range: denormalise to exponent 1, the hidden bit then decides exp 0 vs 1
        if ($signed(e) < 14'sd1) begin
            d = 14'd1 - e;
            sh = m >> d;
            m = sh | {127'b0, (sh << d) != m};
            e = 14'd1;
        end
        st = |m[73:0];
        rnd = m[74] & (st | m[75]);
        sum = {1'b0, m[127:75]} + {53'b0, rnd};
        ef = sum[53] ? e + 14'd1 : (sum[52] ? e : 14'd0);
        y = spec ? y_spec :
            ($signed(ef) > 14'sd2046) ? {sr, 11'h7FF, 52'b0} :
            {sr, ef[10:0], sum[53] ? 52'b0 : sum[51:0]};
    end
endmodule

module fpu_rr_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [64*NUM_REQ-1:0] req_a,
    input  logic [64*NUM_REQ-1:0] req_b,
    input  logic [2*NUM_REQ-1:0]  req_op,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [ID_W-1:0]       rsp_id,
    output logic [63:0]           rsp_result,
    output logic                  busy
);
    logic            s1_valid, s2_valid, found, s2_free, s1_adv, s1_free, accept;
    logic [63:0]     s1_a, s1_b, s2_res, fpu_y;
    logic [1:0]      s1_op;
    logic [ID_W-1:0] s1_id, s2_id, rr_ptr, g;

    fpu_core u_fpu (.a(s1_a), .b(s1_b), .op(s1_op), .y(fpu_y));

    assign s2_free = !s2_valid | rsp_ready;
    assign s1_adv  = s1_valid & s2_free;
    assign s1_free = !s1_valid | s2_free;

    always_comb begin
        found = 1'b0;
        g = '0;
        for (int k = 0; k < NUM_REQ; k++)
            if (!found && req_valid[(int'(rr_ptr) + k) % NUM_REQ]) begin
                found = 1'b1;
                g = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
            end
    end

    assign accept    = found & s1_free & rst_n;
    assign req_ready = accept ? (NUM_REQ'(1) << g) : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            rr_ptr   <= '0;
            s2_id    <= '0;
            s2_res   <= '0;
        end else begin
            if (accept) begin
                s1_a     <= req_a[64*g +: 64];
                s1_b     <= req_b[64*g +: 64];
                s1_op    <= req_op[2*g +: 2];
                s1_id    <= g;
                s1_valid <= 1'b1;
                rr_ptr   <= (g == ID_W'(NUM_REQ - 1)) ? '0 : g + 1'b1;
            end else if (s1_adv) begin
                s1_valid <= 1'b0;
            end
            if (s1_adv) begin
                s2_res   <= fpu_y;
                s2_id    <= s1_id;
                s2_valid <= 1'b1;
            end else if (rsp_ready) begin
                s2_valid <= 1'b0;
            end
        end
    end

    assign rsp_valid  = s2_valid;
    assign rsp_id     = s2_id;
    assign rsp_result = s2_res;
    assign busy       = s1_valid | s2_valid;
endmodule
